// File: rtl/cache_ctrl.sv
// cache_ctrl: single-outstanding request/miss controller in front of a
// direct-mapped cache. Reads are looked up in the cache and refilled from
// memory on a miss. Writes go to the cache and to memory (write-through,
// write-allocate). The controller keeps its own per-line valid bits because
// the cache arrays come out of reset with arbitrary contents. It also keeps
// saturating read hit/miss counters.
module cache_ctrl #(
    parameter int DW     = 16,
    parameter int AW     = 32,
    parameter int INDEXW = 10,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            resp_valid,
    output logic [DW-1:0]   resp_rdata,
    output logic            c_valid,
    output logic            c_write,
    output logic [AW-1:0]   c_addr,
    output logic [DW-1:0]   c_wdata,
    input  logic [DW-1:0]   c_rdata,
    input  logic            c_ready,
    input  logic            c_hit,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_write,
    output logic [AW-1:0]   mem_req_addr,
    output logic [DW-1:0]   mem_req_wdata,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_resp_rdata,
    output logic [CNTW-1:0] hit_cnt,
    output logic [CNTW-1:0] miss_cnt
);

    localparam int NUM_LINES = 1 << INDEXW;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        WR_MEM  = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        FILL    = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [AW-1:0]          addr_q;
    logic [DW-1:0]          wdata_q;
    logic                   write_q;
    logic                   lookup_phase_r;
    logic [NUM_LINES-1:0]   line_valid_r;

    logic                   accept_s;
    logic                   lookup_eval_s;
    logic                   hit_s;

    // Cache line index of an address (low address bits, direct-mapped).
    function automatic logic [INDEXW-1:0] index_of(input logic [AW-1:0] addr);
        return addr[INDEXW-1:0];
    endfunction

    // c_ready from the cache is only meaningful in the second LOOKUP cycle.
    // The hit decision is taken there from c_hit qualified by our own valid bit,
    // so a stale c_ready left over from a write has no effect.

    // Next-state logic plus the combinational cache and memory request ports.
    always_comb begin
        state_s       = state_r;
        req_ready     = 1'b0;
        accept_s      = 1'b0;
        lookup_eval_s = 1'b0;
        hit_s         = c_hit & line_valid_r[index_of(addr_q)];
        c_valid       = 1'b0;
        c_write       = 1'b0;
        c_addr        = addr_q;
        c_wdata       = wdata_q;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                c_addr    = req_addr;
                c_wdata   = req_wdata;
                if (req_valid) begin
                    accept_s = 1'b1;
                    c_valid  = 1'b1;
                    c_write  = req_write;
                    state_s  = req_write ? WR_MEM : LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (lookup_phase_r) begin
                    lookup_eval_s = 1'b1;
                    state_s       = hit_s ? IDLE : RD_REQ;
                end else begin
                    state_s = LOOKUP;
                end
            end
            WR_MEM: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                if (mem_req_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = WR_MEM;
                end
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (mem_resp_valid) begin
                    state_s = FILL;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            FILL: begin
                // resp_rdata already holds the captured memory data
                c_valid = 1'b1;
                c_write = 1'b1;
                c_wdata = resp_rdata;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and the two-cycle LOOKUP phase bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            lookup_phase_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            lookup_phase_r <= (state_r == LOOKUP) && !lookup_phase_r;
        end
    end

    // Capture the accepted request for use in later states.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= {AW{1'b0}};
            wdata_q <= {DW{1'b0}};
            write_q <= 1'b0;
        end else if (accept_s) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
        end else begin
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
            write_q <= write_q;
        end
    end

    // Response pulse and read data; data is held across write responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= {DW{1'b0}};
        end else if (lookup_eval_s && hit_s) begin
            resp_valid <= 1'b1;
            resp_rdata <= c_rdata;
        end else if ((state_r == RD_WAIT) && mem_resp_valid) begin
            resp_valid <= 1'b1;
            resp_rdata <= mem_resp_rdata;
        end else if ((state_r == WR_MEM) && mem_req_ready && write_q) begin
            resp_valid <= 1'b1;
        end else begin
            resp_valid <= 1'b0;
        end
    end

    // Per-line valid bits: set by write allocation or by a refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_r <= {NUM_LINES{1'b0}};
        end else if (accept_s && req_write) begin
            line_valid_r[index_of(req_addr)] <= 1'b1;
        end else if (state_r == FILL) begin
            line_valid_r[index_of(addr_q)] <= 1'b1;
        end else begin
            line_valid_r <= line_valid_r;
        end
    end

    // Saturating read hit/miss statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= {CNTW{1'b0}};
            miss_cnt <= {CNTW{1'b0}};
        end else if (lookup_eval_s && hit_s) begin
            hit_cnt  <= (hit_cnt == {CNTW{1'b1}}) ? hit_cnt : hit_cnt + CNTW'(1);
        end else if (lookup_eval_s && !hit_s) begin
            miss_cnt <= (miss_cnt == {CNTW{1'b1}}) ? miss_cnt : miss_cnt + CNTW'(1);
        end else begin
            hit_cnt  <= hit_cnt;
            miss_cnt <= miss_cnt;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: behavioural cache and memory models,
// expectations pushed at issue time, a monitor pops and compares.
module tb_cache_ctrl;
    localparam int DW = 16, AW = 32, INDEXW = 10, CNTW = 4;
    localparam int NL = 1 << INDEXW;
    localparam int TW = AW - INDEXW;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic resp_valid;
    logic [DW-1:0] resp_rdata;
    logic c_valid, c_write, c_ready, c_hit;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_resp_rdata;
    logic [CNTW-1:0] hit_cnt, miss_cnt;

    cache_ctrl #(.DW(DW), .AW(AW), .INDEXW(INDEXW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .c_valid(c_valid), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready), .c_hit(c_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit chk; logic [DW-1:0] data; int lat; int acc; } resp_t;
    typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mreq_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } fill_t;
    resp_t resp_q[$];
    mreq_t mreq_q[$];
    fill_t fill_q[$];
    logic [DW-1:0] mem_rd_q[$];
    int mem_ready_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    // Cache model: two-cycle lookup pipeline, tags start at 0, data at DEAD
    logic [TW-1:0] tag_m [NL];
    logic [DW-1:0] data_m [NL];
    logic sa_v, sa_h, sb_v, sb_h;
    logic [DW-1:0] sa_d, sb_d;
    initial begin
        for (int i = 0; i < NL; i++) begin
            tag_m[i] = '0;
            data_m[i] = 16'hDEAD;
        end
        c_ready = 1'b0; c_hit = 1'b0; c_rdata = '0;
        sa_v = 1'b0; sa_h = 1'b0; sa_d = '0; sb_v = 1'b0; sb_h = 1'b0; sb_d = '0;
        forever begin
            @(negedge clk); #1;
            c_ready = sb_v; c_hit = sb_h; c_rdata = sb_d;
            sb_v = sa_v; sb_h = sa_h; sb_d = sa_d;
            sa_v = c_valid;
            sa_h = (tag_m[c_addr[INDEXW-1:0]] == c_addr[AW-1:INDEXW]);
            sa_d = data_m[c_addr[INDEXW-1:0]];
            if (c_valid && c_write) begin
                tag_m[c_addr[INDEXW-1:0]] = c_addr[AW-1:INDEXW];
                data_m[c_addr[INDEXW-1:0]] = c_wdata;
            end
        end
    end

    // Memory model: ready after mem_ready_delay cycles, read data 2 cycles later
    int wait_cnt = 0;
    int rsp_cnt = 0;
    initial begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        forever begin
            @(negedge clk); #1;
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = (mem_rd_q.size() > 0) ? mem_rd_q.pop_front() : 16'h0000;
                end
            end else if (mem_req_valid) begin
                if (wait_cnt < mem_ready_delay) begin
                    wait_cnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    wait_cnt = 0;
                    if (!mem_req_write) rsp_cnt = 2;
                end
            end
        end
    end

    // Monitor: compares responses, memory requests and refill writes
    logic pv, pr, pw;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    initial begin
        resp_t e;
        mreq_t m;
        fill_t f;
        pv = 1'b0; pr = 1'b0; pw = 1'b0; pa = '0; pd = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (resp_valid) begin
                    if (resp_q.size() == 0) begin
                        flag("resp_unexpected");
                    end else begin
                        e = resp_q.pop_front();
                        if (e.chk) check("resp_rdata", resp_rdata, e.data);
                        if (e.lat >= 0) check("resp_latency", cyc - e.acc, e.lat);
                    end
                end
                if (mem_req_valid && pv && !pr) begin
                    check("mem_hold_write", mem_req_write, pw);
                    check("mem_hold_addr", mem_req_addr, pa);
                    check("mem_hold_wdata", mem_req_wdata, pd);
                end
                if (mem_req_valid && mem_req_ready) begin
                    if (mreq_q.size() == 0) begin
                        flag("mem_req_unexpected");
                    end else begin
                        m = mreq_q.pop_front();
                        check("mem_req_write", mem_req_write, m.wr);
                        check("mem_req_addr", mem_req_addr, m.addr);
                        if (m.wr) check("mem_req_wdata", mem_req_wdata, m.wdata);
                    end
                end
                if (c_valid && c_write && !req_ready) begin
                    if (fill_q.size() == 0) begin
                        flag("fill_unexpected");
                    end else begin
                        f = fill_q.pop_front();
                        check("fill_index", c_addr[INDEXW-1:0], f.addr[INDEXW-1:0]);
                        check("fill_data", c_wdata, f.data);
                    end
                end
                pv = mem_req_valid; pr = mem_req_ready; pw = mem_req_write;
                pa = mem_req_addr; pd = mem_req_wdata;
            end
        end
    end

    // Issue one request (call at a negedge); returns at the negedge after accept
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit exp_resp, input bit chk, input logic [DW-1:0] exp_d,
                         input int lat, input bit exp_mem, input bit exp_fill);
        int guard = 0;
        resp_t e;
        mreq_t m;
        fill_t f;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            flag("accept_timeout");
        end else begin
            if (exp_resp) begin
                e.chk = chk; e.data = exp_d; e.lat = lat; e.acc = cyc;
                resp_q.push_back(e);
            end
            if (exp_mem) begin
                m.wr = w; m.addr = a; m.wdata = d;
                mreq_q.push_back(m);
                if (!w) mem_rd_q.push_back(exp_d);
            end
            if (exp_fill) begin
                f.addr = a; f.data = exp_d;
                fill_q.push_back(f);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic rd_hit(input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue(1'b0, a, '0, 1'b1, 1'b1, d, 3, 1'b0, 1'b0);
    endtask

    task automatic rd_miss(input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue(1'b0, a, '0, 1'b1, 1'b1, d, 6, 1'b1, 1'b1);
    endtask

    task automatic drain();
        int g = 0;
        while ((resp_q.size() > 0 || mreq_q.size() > 0 || fill_q.size() > 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) flag("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 16'h0000);
        check("rst_c_valid", c_valid, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_hit_cnt", hit_cnt, 4'h0);
        check("rst_miss_cnt", miss_cnt, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: cold read misses although cache tag matches (line invalid)
        rd_miss(32'h40, 16'hBEEF);
        drain();
        check("t1_miss_cnt", miss_cnt, 4'h1);
        check("t1_hit_cnt", hit_cnt, 4'h0);

        // 2: re-read hits, 3-cycle latency, no memory traffic
        rd_hit(32'h40, 16'hBEEF);
        drain();
        check("t2_hit_cnt", hit_cnt, 4'h1);

        // 3: write-through with 5 stalled cycles, then read hits
        mem_ready_delay = 5;
        issue(1'b1, 32'h80, 16'h1234, 1'b1, 1'b0, 16'h0000, 7, 1'b1, 1'b0);
        drain();
        mem_ready_delay = 0;
        check("t3_miss_cnt", miss_cnt, 4'h1);
        rd_hit(32'h80, 16'h1234);
        drain();
        check("t3_hit_cnt", hit_cnt, 4'h2);

        // 4: conflict at index 0x040 (0x440 vs 0x40), back-to-back after fill
        rd_miss(32'h440, 16'h0440);
        rd_miss(32'h40, 16'hBEEF);
        rd_hit(32'h40, 16'hBEEF);
        drain();
        check("t4_hit_cnt", hit_cnt, 4'h3);
        check("t4_miss_cnt", miss_cnt, 4'h3);

        // 5: reset while waiting for memory (0x840 misses at index 0x040)
        issue(1'b0, 32'h840, '0, 1'b0, 1'b0, 16'h7777, -1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_hit_cnt", hit_cnt, 4'h0);
        check("t5_miss_cnt", miss_cnt, 4'h0);
        check("t5_req_ready", req_ready, 1'b1);
        rd_miss(32'h40, 16'h5A5A);
        drain();
        check("t5_miss_after", miss_cnt, 4'h1);

        // 6: hit counter saturation with CNTW=4
        for (int i = 0; i < 15; i++) rd_hit(32'h40, 16'h5A5A);
        drain();
        check("t6_hit_15", hit_cnt, 4'hF);
        for (int i = 0; i < 5; i++) rd_hit(32'h40, 16'h5A5A);
        drain();
        check("t6_hit_sat", hit_cnt, 4'hF);
        check("t6_miss_cnt", miss_cnt, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
